// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencing controller: state encoding,
// filter_select codes, default timing and the configuration validity rule.
package fir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LATCH     = 3'd1,
        ST_COEF_WAIT = 3'd2,
        ST_FILL      = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    localparam logic [1:0] FSEL_LP   = 2'b00;
    localparam logic [1:0] FSEL_HP   = 2'b01;
    localparam logic [1:0] FSEL_BP   = 2'b10;
    localparam logic [1:0] FSEL_RSVD = 2'b11;

    localparam int DEF_COEF_CYCLES = 24;
    localparam int DEF_FILL_CYCLES = 7;
    localparam int DEF_CNT_W       = 8;

    // A bandpass needs a non-empty band; the reserved code is never usable.
    function automatic logic cfg_is_valid(input logic [15:0] low,
                                          input logic [15:0] hi,
                                          input logic [1:0]  sel);
        logic ok;
        case (sel)
            FSEL_LP, FSEL_HP: ok = 1'b1;
            FSEL_BP:          ok = (low < hi);
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/fir_cfg_check.sv
// Combinational check of the live band/filter request: is it usable, and
// does it differ from the configuration currently latched.
module fir_cfg_check
    import fir_pkg::*;
(
    input  logic [15:0] bandlow,
    input  logic [15:0] bandhi,
    input  logic [1:0]  filter_select,
    input  logic [15:0] cfg_low,
    input  logic [15:0] cfg_hi,
    input  logic [1:0]  cfg_sel,
    output logic        cfg_valid,
    output logic        cfg_changed
);

    assign cfg_valid   = cfg_is_valid(bandlow, bandhi, filter_select);
    assign cfg_changed = ({bandlow, bandhi, filter_select} != {cfg_low, cfg_hi, cfg_sel});

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencing controller for the FIR datapath: latch config, wait for coefficients,
// fill the pipeline, then run. Optional macro FIR_SEQ_CTRL_SAMPLE_CNT_EN adds sample_cnt.
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int COEF_CYCLES = DEF_COEF_CYCLES,
    parameter int FILL_CYCLES = DEF_FILL_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_coe,
    input  logic        hold,
    input  logic [15:0] bandlow,
    input  logic [15:0] bandhi,
    input  logic [1:0]  filter_select,
    output logic        cfg_load,
    output logic [15:0] cfg_low,
    output logic [15:0] cfg_hi,
    output logic [1:0]  cfg_sel,
    output logic        flag,
    output logic        start_togivedata,
    output logic        start_toread,
    output logic        cfg_err,
    output logic [2:0]  state_o
`ifdef FIR_SEQ_CTRL_SAMPLE_CNT_EN
    ,
    output logic [31:0] sample_cnt
`endif
);

    localparam logic [CNT_W-1:0] COEF_LAST = CNT_W'(COEF_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cfg_err_nxt;
    logic             cfg_valid;
    logic             cfg_changed;
    logic             restart;

    fir_cfg_check u_cfg_check (
        .bandlow      (bandlow),
        .bandhi       (bandhi),
        .filter_select(filter_select),
        .cfg_low      (cfg_low),
        .cfg_hi       (cfg_hi),
        .cfg_sel      (cfg_sel),
        .cfg_valid    (cfg_valid),
        .cfg_changed  (cfg_changed)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cfg_err <= 1'b0;
            cfg_low <= '0;
            cfg_hi  <= '0;
            cfg_sel <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cfg_err <= cfg_err_nxt;
            if (state == ST_LATCH) begin
                cfg_low <= bandlow;
                cfg_hi  <= bandhi;
                cfg_sel <= filter_select;
            end
        end
    end

    // Once a config is latched, any edit to the request restarts the sequence
    // and takes priority over the wait counters.
    assign restart = cfg_changed &&
                     ((state == ST_COEF_WAIT) || (state == ST_FILL) || (state == ST_RUN));

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cfg_err_nxt = cfg_err;
        if (restart) begin
            if (cfg_valid) begin
                state_nxt = ST_LATCH;
            end else begin
                state_nxt   = ST_IDLE;
                cfg_err_nxt = 1'b1;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_coe) begin
                        if (cfg_valid) begin
                            state_nxt   = ST_LATCH;
                            cfg_err_nxt = 1'b0;
                        end else begin
                            cfg_err_nxt = 1'b1;
                        end
                    end
                end
                ST_LATCH: begin
                    cnt_nxt   = '0;
                    state_nxt = ST_COEF_WAIT;
                end
                ST_COEF_WAIT: begin
                    if (cnt == COEF_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_FILL;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_FILL: begin
                    // Pipeline fill only progresses while downstream accepts data.
                    if (!hold) begin
                        if (cnt == FILL_LAST) begin
                            state_nxt = ST_RUN;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    state_nxt = ST_RUN;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_load         = (state == ST_LATCH);
    assign flag             = (state == ST_FILL) || (state == ST_RUN);
    assign start_togivedata = flag & ~hold;
    assign start_toread     = (state == ST_RUN) & ~hold;
    assign state_o          = state;

`ifdef FIR_SEQ_CTRL_SAMPLE_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt <= '0;
        end else if (cfg_load) begin
            sample_cnt <= '0;
        end else if (start_toread) begin
            sample_cnt <= sample_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl: timeline-based reference model, directed
// latency/hold/error/restart/reset scenarios, then randomized traffic.
module tb_fir_seq_ctrl;

    localparam int COEF = 24;
    localparam int FILL = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_coe = 1'b0;
    logic        hold = 1'b0;
    logic [15:0] bandlow = 16'h0;
    logic [15:0] bandhi = 16'h0;
    logic [1:0]  filter_select = 2'b00;
    logic        cfg_load;
    logic [15:0] cfg_low;
    logic [15:0] cfg_hi;
    logic [1:0]  cfg_sel;
    logic        flag;
    logic        start_togivedata;
    logic        start_toread;
    logic        cfg_err;
    logic [2:0]  state_o;
`ifdef FIR_SEQ_CTRL_SAMPLE_CNT_EN
    logic [31:0] sample_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    fir_seq_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .start_coe       (start_coe),
        .hold            (hold),
        .bandlow         (bandlow),
        .bandhi          (bandhi),
        .filter_select   (filter_select),
        .cfg_load        (cfg_load),
        .cfg_low         (cfg_low),
        .cfg_hi          (cfg_hi),
        .cfg_sel         (cfg_sel),
        .flag            (flag),
        .start_togivedata(start_togivedata),
        .start_toread    (start_toread),
        .cfg_err         (cfg_err),
        .state_o         (state_o)
`ifdef FIR_SEQ_CTRL_SAMPLE_CNT_EN
        ,
        .sample_cnt      (sample_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at cycle-time %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a sequence is described by the cycle L of its config-load
    // pulse and the number of unstalled fill cycles completed since flag rose.
    bit          m_active = 1'b0;
    bit          m_err = 1'b0;
    int          m_cyc = 0;
    int          m_L = -1000;
    int          m_fill = 0;
    logic [15:0] m_low = 16'h0;
    logic [15:0] m_hi = 16'h0;
    logic [1:0]  m_sel = 2'b00;
    logic [31:0] m_scnt = 32'h0;

    function automatic bit mdl_valid(input logic [15:0] lo, input logic [15:0] hi, input logic [1:0] sel);
        if (sel == 2'd3) return 1'b0;
        if (sel == 2'd2) return (lo < hi);
        return 1'b1;
    endfunction

    function automatic bit e_load();
        return reset && m_active && (m_cyc == m_L);
    endfunction

    function automatic bit e_flag();
        return reset && m_active && (m_cyc >= m_L + COEF + 1);
    endfunction

    function automatic bit e_run();
        return e_flag() && (m_fill >= FILL);
    endfunction

    function automatic logic [2:0] e_state();
        if (!reset || !m_active) return 3'd0;
        if (m_cyc == m_L)        return 3'd1;
        if (!e_flag())           return 3'd2;
        if (!e_run())            return 3'd3;
        return 3'd4;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_active = 1'b0;
                m_err    = 1'b0;
                m_L      = -1000;
                m_fill   = 0;
                m_low    = 16'h0;
                m_hi     = 16'h0;
                m_sel    = 2'b00;
                m_scnt   = 32'h0;
            end else begin
                if (e_load())
                    m_scnt = 32'h0;
                else if (e_run() && !hold)
                    m_scnt = m_scnt + 32'd1;
                if (!m_active) begin
                    if (start_coe) begin
                        if (mdl_valid(bandlow, bandhi, filter_select)) begin
                            m_active = 1'b1;
                            m_L      = m_cyc + 1;
                            m_fill   = 0;
                            m_err    = 1'b0;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                end else if (m_cyc == m_L) begin
                    m_low = bandlow;
                    m_hi  = bandhi;
                    m_sel = filter_select;
                end else if ({bandlow, bandhi, filter_select} != {m_low, m_hi, m_sel}) begin
                    if (mdl_valid(bandlow, bandhi, filter_select)) begin
                        m_L    = m_cyc + 1;
                        m_fill = 0;
                    end else begin
                        m_active = 1'b0;
                        m_err    = 1'b1;
                    end
                end else if ((m_cyc >= m_L + COEF + 1) && !hold && (m_fill < FILL)) begin
                    m_fill = m_fill + 1;
                end
            end
            m_cyc = m_cyc + 1;
        end
    end

    // Every-cycle comparison at the falling edge, midway between input changes and clock edges.
    initial begin
        forever begin
            @(negedge clk);
            chk("cfg_load", 32'(cfg_load), 32'(e_load()));
            chk("flag", 32'(flag), 32'(e_flag()));
            chk("start_togivedata", 32'(start_togivedata), 32'(e_flag() && !hold));
            chk("start_toread", 32'(start_toread), 32'(e_run() && !hold));
            chk("state_o", 32'(state_o), 32'(e_state()));
            chk("cfg_err", 32'(cfg_err), 32'(reset ? m_err : 1'b0));
            chk("cfg_low", 32'(cfg_low), 32'(reset ? m_low : 16'h0));
            chk("cfg_hi", 32'(cfg_hi), 32'(reset ? m_hi : 16'h0));
            chk("cfg_sel", 32'(cfg_sel), 32'(reset ? m_sel : 2'b00));
`ifdef FIR_SEQ_CTRL_SAMPLE_CNT_EN
            chk("sample_cnt", sample_cnt, reset ? m_scnt : 32'h0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_to(input int n);
        while (m_cyc < n) tick();
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        start_coe     = 1'b0;
        hold          = 1'b0;
        bandlow       = 16'h0;
        bandhi        = 16'h0;
        filter_select = 2'b00;
        tick();
        tick();
        reset = 1'b1;
    endtask

    logic [15:0] lo_pool [6] = '{16'h0100, 16'h0000, 16'h1234, 16'h0800, 16'h0100, 16'h0200};
    logic [15:0] hi_pool [6] = '{16'h0800, 16'h0000, 16'h5678, 16'h0100, 16'h0800, 16'h0200};
    logic [1:0]  sel_pool[6] = '{2'b10,    2'b00,    2'b01,    2'b10,    2'b11,    2'b10};

    initial begin
        int s;
        int c;
        int idx;

        // Basic sequence: latency of load, flag and first read.
        do_reset();
        #1;
        chk("rst_state_o", 32'(state_o), 32'd0);
        chk("rst_flag", 32'(flag), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        bandlow = 16'h0100; bandhi = 16'h0800; filter_select = 2'b10; start_coe = 1'b1;
        s = m_cyc;
        tick(); start_coe = 1'b0;
        #1 chk("lit_load_k1", 32'(cfg_load), 32'd1);
        wait_to(s + 25); #1 chk("lit_flag_k25", 32'(flag), 32'd0);
        wait_to(s + 26); #1 chk("lit_flag_k26", 32'(flag), 32'd1);
        chk("lit_give_k26", 32'(start_togivedata), 32'd1);
        wait_to(s + 32); #1 chk("lit_read_k32", 32'(start_toread), 32'd0);
        wait_to(s + 33); #1 chk("lit_read_k33", 32'(start_toread), 32'd1);
        chk("lit_state_run", 32'(state_o), 32'd4);

        // Hold during FILL stretches the fill window by the stall length.
        do_reset();
        bandlow = 16'h0100; bandhi = 16'h0800; filter_select = 2'b10; start_coe = 1'b1;
        s = m_cyc;
        tick(); start_coe = 1'b0;
        wait_to(s + 28); hold = 1'b1;
        #1 chk("lit_give_hold", 32'(start_togivedata), 32'd0);
        wait_to(s + 33); hold = 1'b0;
        wait_to(s + 37); #1 chk("lit_hold_read_k37", 32'(start_toread), 32'd0);
        wait_to(s + 38); #1 chk("lit_hold_read_k38", 32'(start_toread), 32'd1);

        // Invalid request, then a valid one that clears the error.
        do_reset();
        bandlow = 16'h0800; bandhi = 16'h0100; filter_select = 2'b10; start_coe = 1'b1;
        tick(); start_coe = 1'b0;
        #1 chk("lit_err_set", 32'(cfg_err), 32'd1);
        chk("lit_err_state", 32'(state_o), 32'd0);
        chk("lit_err_noload", 32'(cfg_load), 32'd0);
        bandlow = 16'h0100; bandhi = 16'h0800; start_coe = 1'b1;
        s = m_cyc;
        tick(); start_coe = 1'b0;
        #1 chk("lit_err_clear", 32'(cfg_err), 32'd0);
        chk("lit_err_load", 32'(cfg_load), 32'd1);

        // Config change while running restarts the sequence.
        wait_to(s + 43);
`ifdef FIR_SEQ_CTRL_SAMPLE_CNT_EN
        #1 chk("lit_sample_cnt_10", sample_cnt, 32'd10);
`endif
        bandhi = 16'h0900;
        c = m_cyc;
        tick();
        #1 chk("lit_chg_flag_drop", 32'(flag), 32'd0);
        chk("lit_chg_load", 32'(cfg_load), 32'd1);
        wait_to(c + 2); #1 chk("lit_chg_cfg_hi", 32'(cfg_hi), 32'h0900);
`ifdef FIR_SEQ_CTRL_SAMPLE_CNT_EN
        chk("lit_sample_cnt_clr", sample_cnt, 32'd0);
`endif
        wait_to(c + 25); #1 chk("lit_chg_flag_c25", 32'(flag), 32'd0);
        wait_to(c + 26); #1 chk("lit_chg_flag_c26", 32'(flag), 32'd1);

        // Asynchronous reset in RUN clears everything at once.
        wait_to(c + 34);
        #1 reset = 1'b0;
        #1 chk("lit_arst_state", 32'(state_o), 32'd0);
        chk("lit_arst_flag", 32'(flag), 32'd0);
        chk("lit_arst_read", 32'(start_toread), 32'd0);
        chk("lit_arst_cfg_hi", 32'(cfg_hi), 32'd0);
        tick(); reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bandhi = 16'h0A00 + 16'(i);
            tick();
        end
        #1 chk("lit_arst_idle", 32'(state_o), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset     = 1'b1;
            if ($urandom_range(0, 999) == 0) reset = 1'b0;
            start_coe = ($urandom_range(0, 9) == 0);
            hold      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 59) == 0) begin
                idx           = int'($urandom_range(0, 5));
                bandlow       = lo_pool[idx];
                bandhi        = hi_pool[idx];
                filter_select = sel_pool[idx];
            end
        end
        reset = 1'b1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
